core_stage_buf: RTL and testbench

Parametrised pipeline stage buffer that replaces the fixed single-register hand-off between core stages (decode→execute, execute→memory, memory→writeback). It carries an opaque WIDTH-bit stage payload through a DEPTH-entry in-order buffer with a valid/ready handshake on both sides. It also provides hazard-unit stall, branch-unit flush and a selectable ready mode. Each stage interface instantiates one buffer sized to its payload.

---
 rtl/core_stage_buf_if.sv | 27 ++
 rtl/core_stage_buf.sv | 91 +++++++++
 tb/tb_core_stage_buf.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_stage_buf_if.sv
// rtl/core_stage_buf_if.sv - handshake bundle between two core stages and their stage buffer
interface core_stage_buf_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             stall;
    logic             flush;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, out_ready, stall, flush,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, stall, flush,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/core_stage_buf.sv
// rtl/core_stage_buf.sv - in-order DEPTH-entry stage buffer with stall, flush and selectable ready mode
module core_stage_buf #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int PIPE_READY = 0
) (
    input  logic               clk,
    input  logic               rst,
    core_stage_buf_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic hold;
    logic full;
    logic in_ready;
    logic out_valid;
    logic enq;
    logic deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake: flush and stall both mask the two sides, so neither event can fire.
    always_comb begin
        hold      = bus.flush | bus.stall;
        full      = (count_q == FULL_CNT);
        in_ready  = !hold && (!full || ((PIPE_READY != 0) && bus.out_ready));
        out_valid = !hold && (count_q != '0);
        enq       = bus.in_valid & in_ready;
        deq       = out_valid & bus.out_ready;
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            // Storage is left untouched; only the bookkeeping is cleared.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = bus.in_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Output data comes straight from storage; no in_data bypass exists.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_core_stage_buf.sv
// tb/tb_core_stage_buf.sv - self-checking bench for core_stage_buf in three configurations
module tb_core_stage_buf;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_stage_buf_if #(.WIDTH(8), .DEPTH(2)) b0 ();
    core_stage_buf_if #(.WIDTH(8), .DEPTH(3)) b1 ();
    core_stage_buf_if #(.WIDTH(8), .DEPTH(1)) b2 ();

    assign b0.in_valid = in_valid;  assign b0.in_data = in_data;  assign b0.out_ready = out_ready;
    assign b0.stall    = stall;     assign b0.flush   = flush;
    assign b1.in_valid = in_valid;  assign b1.in_data = in_data;  assign b1.out_ready = out_ready;
    assign b1.stall    = stall;     assign b1.flush   = flush;
    assign b2.in_valid = in_valid;  assign b2.in_data = in_data;  assign b2.out_ready = out_ready;
    assign b2.stall    = stall;     assign b2.flush   = flush;

    core_stage_buf #(.WIDTH(8), .DEPTH(2), .PIPE_READY(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    core_stage_buf #(.WIDTH(8), .DEPTH(3), .PIPE_READY(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    core_stage_buf #(.WIDTH(8), .DEPTH(1), .PIPE_READY(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       orr;
        logic       st;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic       chk_od;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[16];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] got[$];

    function automatic vec_t mk(logic iv, logic [7:0] d, logic orr, logic st, logic fl,
                                logic e_ir, logic e_ov, logic chk_od, logic [7:0] e_od,
                                logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.orr = orr; v.st = st; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.chk_od = chk_od; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic orr,
                         input logic st, input logic fl);
        in_valid = iv; in_data = d; out_ready = orr; stall = st; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    // Reference: the buffer is an ordered queue of at most depth words.
    task automatic model(ref logic [7:0] q[$], input int depth, input bit pipe,
                         input logic a_ir, input logic a_ov, input logic [7:0] a_od,
                         input logic [31:0] a_cnt, input string tag);
        bit e_ir;
        bit e_ov;
        e_ir = !flush && !stall && (q.size() < depth || (pipe && q.size() == depth && out_ready));
        e_ov = !flush && !stall && (q.size() != 0);
        chk({tag, "_in_ready"}, a_ir, e_ir);
        chk({tag, "_out_valid"}, a_ov, e_ov);
        chk({tag, "_count"}, a_cnt, q.size());
        chk({tag, "_count_bound"}, a_cnt <= depth, 1);
        if (q.size() != 0) chk({tag, "_out_data"}, a_od, q[0]);
        if (flush) begin
            q.delete();
        end else if (!stall) begin
            if (e_ov && out_ready) void'(q.pop_front());
            if (in_valid && e_ir) q.push_back(in_data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int idx;

        tbl[0]  = mk(1, 8'h11, 1, 0, 0, 1, 0, 1, 8'h00, 0);
        tbl[1]  = mk(1, 8'h22, 1, 0, 0, 1, 1, 1, 8'h11, 1);
        tbl[2]  = mk(1, 8'h33, 1, 0, 0, 1, 1, 1, 8'h22, 1);
        tbl[3]  = mk(1, 8'h44, 1, 0, 0, 1, 1, 1, 8'h33, 1);
        tbl[4]  = mk(1, 8'h55, 1, 0, 0, 1, 1, 1, 8'h44, 1);
        tbl[5]  = mk(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h55, 1);
        tbl[6]  = mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[7]  = mk(1, 8'h66, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[8]  = mk(1, 8'h77, 0, 1, 0, 0, 0, 0, 8'h00, 1);
        tbl[9]  = mk(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h66, 1);
        tbl[10] = mk(1, 8'h88, 0, 0, 0, 1, 0, 0, 8'h00, 0);
        tbl[11] = mk(1, 8'h89, 0, 0, 0, 1, 1, 1, 8'h88, 1);
        tbl[12] = mk(1, 8'h8A, 0, 0, 0, 0, 1, 1, 8'h88, 2);
        tbl[13] = mk(1, 8'h8A, 1, 0, 0, 0, 1, 1, 8'h88, 2);
        tbl[14] = mk(1, 8'h8A, 1, 0, 1, 0, 0, 0, 8'h00, 1);
        tbl[15] = mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0);

        // Reset state of every configuration
        #1;
        chk("rst_cnt0", b0.count, 0);  chk("rst_ov0", b0.out_valid, 0);
        chk("rst_ir0", b0.in_ready, 1); chk("rst_od0", b0.out_data, 0);
        chk("rst_cnt1", b1.count, 0);  chk("rst_ir2", b2.in_ready, 1);
        do_reset();

        // Streaming, stall and backpressure vectors on DEPTH=2, PIPE_READY=0
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].orr, tbl[i].st, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), b0.in_ready, tbl[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), b0.out_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d_count", i), b0.count, tbl[i].e_cnt);
            if (tbl[i].chk_od) chk($sformatf("vec%0d_out_data", i), b0.out_data, tbl[i].e_od);
            next_cycle();
        end

        // Asynchronous reset mid-stream with two entries held
        do_reset();
        drive(1, 8'hC1, 0, 0, 0); next_cycle();
        drive(1, 8'hC2, 0, 0, 0); next_cycle();
        drive(0, 8'h00, 0, 0, 0);
        chk("areset_pre_count", b0.count, 2);
        #1 rst = 1'b1;
        #1;
        chk("areset_count", b0.count, 0);
        chk("areset_out_valid", b0.out_valid, 0);
        chk("areset_out_data", b0.out_data, 0);
        chk("areset_in_ready", b0.in_ready, 1);
        next_cycle();
        rst = 1'b0;

        // Backpressure and pointer wrap on DEPTH=3
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 8'hA0 + 8'(k), 0, 0, 0);
            @(negedge clk);
            chk($sformatf("bp_in_ready%0d", k), b1.in_ready, k < 3);
            next_cycle();
        end
        chk("bp_full_count", b1.count, 3);
        got.delete();
        idx = 3;
        guard = 0;
        while (got.size() < 7 && guard < 40) begin
            drive(idx <= 6, 8'hA0 + 8'(idx), 1, 0, 0);
            @(negedge clk);
            if (b1.out_valid) got.push_back(b1.out_data);
            if (in_valid && b1.in_ready) idx++;
            next_cycle();
            guard++;
        end
        chk("bp_collected", got.size(), 7);
        for (int k = 0; k < got.size(); k++) chk($sformatf("bp_order%0d", k), got[k], 8'hA0 + k);

        // Pipe-ready mode on DEPTH=1: full buffer still accepts while draining
        do_reset();
        drive(1, 8'h05, 0, 0, 0);
        @(negedge clk);
        chk("pr_first_in_ready", b2.in_ready, 1);
        next_cycle();
        for (int w = 6; w <= 9; w++) begin
            drive(1, 8'(w), 1, 0, 0);
            @(negedge clk);
            chk($sformatf("pr_in_ready_%0d", w), b2.in_ready, 1);
            chk($sformatf("pr_out_valid_%0d", w), b2.out_valid, 1);
            chk($sformatf("pr_out_data_%0d", w), b2.out_data, w - 1);
            chk($sformatf("pr_count_%0d", w), b2.count, 1);
            next_cycle();
        end
        drive(0, 8'h00, 1, 0, 0);
        @(negedge clk);
        chk("pr_last_data", b2.out_data, 9);
        chk("pr_last_valid", b2.out_valid, 1);
        next_cycle();
        chk("pr_drained", b2.count, 0);

        // Flush with two entries and a word offered in the same cycle
        do_reset();
        drive(1, 8'h31, 0, 0, 0); next_cycle();
        drive(1, 8'h32, 0, 0, 0); next_cycle();
        drive(1, 8'h77, 1, 0, 1);
        @(negedge clk);
        chk("fl_in_ready", b0.in_ready, 0);
        chk("fl_out_valid", b0.out_valid, 0);
        chk("fl_count_before", b0.count, 2);
        next_cycle();
        drive(0, 8'h00, 1, 0, 0);
        chk("fl_count_after", b0.count, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("fl_no_output%0d", k), b0.out_valid, 0);
            next_cycle();
        end

        // Stall held for three cycles with one entry inside
        do_reset();
        drive(1, 8'h99, 0, 0, 0); next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'hAB, 1, 1, 0);
            @(negedge clk);
            chk($sformatf("st_out_valid%0d", k), b0.out_valid, 0);
            chk($sformatf("st_in_ready%0d", k), b0.in_ready, 0);
            chk($sformatf("st_count%0d", k), b0.count, 1);
            next_cycle();
        end
        drive(0, 8'h00, 1, 0, 0);
        @(negedge clk);
        chk("st_release_valid", b0.out_valid, 1);
        chk("st_release_data", b0.out_data, 8'h99);
        next_cycle();

        // Randomized traffic against the queue model for all three configurations
        do_reset();
        q0.delete(); q1.delete(); q2.delete();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom),
                  (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
            @(negedge clk);
            model(q0, 2, 1'b0, b0.in_ready, b0.out_valid, b0.out_data, b0.count, "rnd_d2");
            model(q1, 3, 1'b0, b1.in_ready, b1.out_valid, b1.out_data, b1.count, "rnd_d3");
            model(q2, 1, 1'b1, b2.in_ready, b2.out_valid, b2.out_data, b2.count, "rnd_d1p");
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
